pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It owns the write-enable and bubble/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch flushes and data-memory wait states, and drains the pipe with bubbles after reset. It sits beside the ID stage and takes hazard inputs from the ID/EX and EX/MEM register outputs.

---
 rtl/pipe_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline sequencing controller for the 5-stage MIPS core. It owns the
// write enables and the bubble/flush controls of the PC, IF/ID, ID/EX, EX/MEM
// and MEM/WB registers. It resolves load-use hazards, taken-branch flushes
// and data-memory wait states. After reset it drains the pipe with bubbles.
//
// Parameters
//   R_WIDTH    register-specifier width
//   RST_DRAIN  bubble cycles inserted after reset (1..15)
//   TIMEOUT    MWAIT cycles before err_o sets (1..255)
//
// Ports
//   clk_i           clock; all state updates on the rising edge
//   rst_i           synchronous active-high reset
//   id_rs_i         rs field of the instruction in ID
//   id_rt_i         rt field of the instruction in ID
//   id_uses_rt_i    the instruction in ID reads rt as a source
//   ex_rt_i         rt of the instruction in EX (ID/EX register)
//   ex_mem_read_i   the instruction in EX is a load
//   branch_taken_i  branch resolved taken in EX
//   mem_req_i       MEM stage is performing a data-memory access
//   mem_ack_i       the data-memory access completes this cycle
//   pc_we_o         PC write enable
//   if_id_we_o      IF/ID write enable
//   if_id_flush_o   load a NOP into IF/ID
//   id_ex_we_o      ID/EX write enable
//   id_ex_bubble_o  zero the WB/MEM/EX control fields on the ID/EX load
//   ex_mem_we_o     EX/MEM write enable
//   mem_wb_we_o     MEM/WB write enable
//   state_o         FSM state: DRAIN=0, RUN=1, MWAIT=2
//   stall_cnt_o     saturating count of cycles with the PC held outside DRAIN
//   err_o           sticky: a memory wait exceeded TIMEOUT
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int R_WIDTH   = 5,
   parameter int RST_DRAIN = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [R_WIDTH-1:0] id_rs_i,
   input  logic [R_WIDTH-1:0] id_rt_i,
   input  logic               id_uses_rt_i,
   input  logic [R_WIDTH-1:0] ex_rt_i,
   input  logic               ex_mem_read_i,
   input  logic               branch_taken_i,
   input  logic               mem_req_i,
   input  logic               mem_ack_i,
   output logic               pc_we_o,
   output logic               if_id_we_o,
   output logic               if_id_flush_o,
   output logic               id_ex_we_o,
   output logic               id_ex_bubble_o,
   output logic               ex_mem_we_o,
   output logic               mem_wb_we_o,
   output logic [1:0]         state_o,
   output logic [15:0]        stall_cnt_o,
   output logic               err_o
);

   typedef enum logic [1:0] {
      ST_DRAIN = 2'd0,
      ST_RUN   = 2'd1,
      ST_MWAIT = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      ACT_NORMAL = 3'd0,
      ACT_FREEZE = 3'd1,
      ACT_FLUSH  = 3'd2,
      ACT_STALL  = 3'd3,
      ACT_DRAIN  = 3'd4
   } action_t;

   localparam logic [3:0]  DRAIN_INIT  = 4'(RST_DRAIN - 1);
   localparam logic [7:0]  TIMEOUT_M1  = 8'(TIMEOUT - 1);
   localparam logic [7:0]  WAIT_MAX    = 8'hFF;
   localparam logic [15:0] STALL_MAX   = 16'hFFFF;

   state_t      state_q;
   state_t      state_d;
   action_t     run_act;
   action_t     act;
   logic [3:0]  drain_cnt_q;
   logic [7:0]  wait_cnt_q;
   logic [15:0] stall_cnt_q;
   logic        err_q;
   logic        lu;
   logic        mw;

   // Hazard terms. A load into r0 never creates a dependency because r0 is
   // hard-wired to zero; rt only matters when ID actually reads it.
   always_comb begin
      lu = ex_mem_read_i && (ex_rt_i != '0) &&
           ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
      mw = mem_req_i && !mem_ack_i;
   end

   // Action priority used in RUN and on the ack cycle of MWAIT. A memory wait
   // freezes everything, so a simultaneous branch is simply re-seen once the
   // freeze lifts. A taken branch beats load-use because the dependent
   // instruction in ID is discarded by the flush anyway.
   always_comb begin
      run_act = ACT_NORMAL;
      if (mw) begin
         run_act = ACT_FREEZE;
      end else if (branch_taken_i) begin
         run_act = ACT_FLUSH;
      end else if (lu) begin
         run_act = ACT_STALL;
      end
   end

   // Next-state and action selection. While reset is high the outputs show
   // the drain action no matter what the state register holds, so the pipe
   // is already bubbling during the reset cycle itself.
   always_comb begin
      state_d = state_q;
      act     = ACT_NORMAL;
      if (rst_i) begin
         state_d = ST_DRAIN;
         act     = ACT_DRAIN;
      end else begin
         case (state_q)
            ST_DRAIN: begin
               act = ACT_DRAIN;
               if (drain_cnt_q == 4'd0) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               act = run_act;
               if (mw) begin
                  state_d = ST_MWAIT;
               end
            end
            ST_MWAIT: begin
               if (mem_ack_i) begin
                  act     = run_act;
                  state_d = ST_RUN;
               end else begin
                  act = ACT_FREEZE;
               end
            end
            default: begin
               act     = ACT_DRAIN;
               state_d = ST_DRAIN;
            end
         endcase
      end
   end

   // Decode the selected action into the individual register controls.
   // Anything an action does not mention stays at its benign value:
   // enables high, flush and bubble low.
   always_comb begin
      pc_we_o        = 1'b1;
      if_id_we_o     = 1'b1;
      if_id_flush_o  = 1'b0;
      id_ex_we_o     = 1'b1;
      id_ex_bubble_o = 1'b0;
      ex_mem_we_o    = 1'b1;
      mem_wb_we_o    = 1'b1;
      case (act)
         ACT_FREEZE: begin
            pc_we_o     = 1'b0;
            if_id_we_o  = 1'b0;
            id_ex_we_o  = 1'b0;
            ex_mem_we_o = 1'b0;
            mem_wb_we_o = 1'b0;
         end
         ACT_FLUSH: begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
         end
         ACT_STALL: begin
            pc_we_o        = 1'b0;
            if_id_we_o     = 1'b0;
            id_ex_bubble_o = 1'b1;
         end
         ACT_DRAIN: begin
            pc_we_o        = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // State register. Reset from any state, including mid-wait or mid-drain,
   // restarts the full drain sequence.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_DRAIN;
      end else begin
         state_q <= state_d;
      end
   end

   // Drain counter. It is loaded with RST_DRAIN-1 so that the DRAIN state
   // lasts exactly RST_DRAIN cycles once reset falls; it leaves DRAIN on the
   // cycle it reads zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         drain_cnt_q <= DRAIN_INIT;
      end else if ((state_q == ST_DRAIN) && (drain_cnt_q != 4'd0)) begin
         drain_cnt_q <= drain_cnt_q - 4'd1;
      end
   end

   // Wait counter. Cleared when a wait begins and when it ends, counts each
   // unacknowledged MWAIT cycle, and saturates rather than wrapping so a very
   // long hang cannot alias back below the timeout.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wait_cnt_q <= 8'd0;
      end else if ((state_q == ST_RUN) && mw) begin
         wait_cnt_q <= 8'd0;
      end else if (state_q == ST_MWAIT) begin
         if (mem_ack_i) begin
            wait_cnt_q <= 8'd0;
         end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
         end
      end
   end

   // Timeout flag. It sets on the edge where the wait counter steps up to
   // TIMEOUT and stays set until reset; the FSM keeps waiting regardless.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if ((state_q == ST_MWAIT) && !mem_ack_i &&
                   (wait_cnt_q == TIMEOUT_M1)) begin
         err_q <= 1'b1;
      end
   end

   // Stall statistics: every cycle outside DRAIN in which the PC is held
   // (freeze or load-use stall). Saturates at all-ones.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= 16'd0;
      end else if ((state_q != ST_DRAIN) && !pc_we_o &&
                   (stall_cnt_q != STALL_MAX)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign state_o     = rst_i ? ST_DRAIN : state_q;
   assign stall_cnt_o = stall_cnt_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl with RST_DRAIN=2 and TIMEOUT=4.
// Each step drives the inputs just after a rising edge, checks the
// combinational controls plus the registered state/counters before the next
// edge, then advances one clock.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   localparam int RW = 5;

   // Control vector order: pc_we, if_id_we, if_id_flush, id_ex_we,
   // id_ex_bubble, ex_mem_we, mem_wb_we.
   localparam logic [6:0] C_NORMAL = 7'b1101011;
   localparam logic [6:0] C_FREEZE = 7'b0000000;
   localparam logic [6:0] C_FLUSH  = 7'b1111111;
   localparam logic [6:0] C_STALL  = 7'b0001111;
   localparam logic [6:0] C_DRAIN  = 7'b0111111;

   logic          clk;
   logic          rst;
   logic [RW-1:0] idRs;
   logic [RW-1:0] idRt;
   logic          idUsesRt;
   logic [RW-1:0] exRt;
   logic          exMemRead;
   logic          branchTaken;
   logic          memReq;
   logic          memAck;
   logic          pcWe;
   logic          ifIdWe;
   logic          ifIdFlush;
   logic          idExWe;
   logic          idExBubble;
   logic          exMemWe;
   logic          memWbWe;
   logic [1:0]    stateOut;
   logic [15:0]   stallCnt;
   logic          err;

   int nChecks;
   int nPass;

   pipe_hazard_ctrl #(
      .R_WIDTH   (RW),
      .RST_DRAIN (2),
      .TIMEOUT   (4)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .id_rs_i        (idRs),
      .id_rt_i        (idRt),
      .id_uses_rt_i   (idUsesRt),
      .ex_rt_i        (exRt),
      .ex_mem_read_i  (exMemRead),
      .branch_taken_i (branchTaken),
      .mem_req_i      (memReq),
      .mem_ack_i      (memAck),
      .pc_we_o        (pcWe),
      .if_id_we_o     (ifIdWe),
      .if_id_flush_o  (ifIdFlush),
      .id_ex_we_o     (idExWe),
      .id_ex_bubble_o (idExBubble),
      .ex_mem_we_o    (exMemWe),
      .mem_wb_we_o    (memWbWe),
      .state_o        (stateOut),
      .stall_cnt_o    (stallCnt),
      .err_o          (err)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory protocol guard: the request must stay up until it is acked.
   always @(negedge clk) begin
      if (!rst && (stateOut == 2'd2) && !memReq && !memAck) begin
         $error("[TB] protocol violation: mem_req dropped during a wait");
      end
   end

   // Drive one cycle's worth of inputs and let the combinational logic settle.
   task automatic applyStimulus(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                input logic usesRt, input logic [RW-1:0] eRt,
                                input logic eMr, input logic br,
                                input logic req, input logic ack);
      idRs        = rs;
      idRt        = rt;
      idUsesRt    = usesRt;
      exRt        = eRt;
      exMemRead   = eMr;
      branchTaken = br;
      memReq      = req;
      memAck      = ack;
      #1;
   endtask

   task automatic applyIdle();
      applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Load-use on rs: ID reads r8, EX is loading r8.
   task automatic applyLoadUse(input logic req, input logic ack);
      applyStimulus(5'd8, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, req, ack);
   endtask

   task automatic checkOutput(input string tag, input logic [6:0] expCtl,
                              input logic [1:0] expState, input logic [15:0] expStall,
                              input logic expErr);
      logic [25:0] obs;
      logic [25:0] exp;
      obs = {pcWe, ifIdWe, ifIdFlush, idExWe, idExBubble, exMemWe, memWbWe,
             stateOut, stallCnt, err};
      exp = {expCtl, expState, expStall, expErr};
      nChecks = nChecks + 1;
      assert (obs === exp) nPass = nPass + 1;
      else $error("[TB] FAIL %s: observed ctl=%b state=%0d stall=%h err=%b, expected ctl=%b state=%0d stall=%h err=%b",
                  tag, obs[25:19], obs[18:17], obs[16:1], obs[0],
                  exp[25:19], exp[18:17], exp[16:1], exp[0]);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      nChecks = 0;
      nPass   = 0;
      rst     = 1'b1;
      applyIdle();

      // Reset and post-reset drain: two DRAIN cycles, then RUN.
      step();
      checkOutput("reset", C_DRAIN, 2'd0, 16'd0, 1'b0);
      step();
      rst = 1'b0;
      applyIdle();
      checkOutput("drain1", C_DRAIN, 2'd0, 16'd0, 1'b0);
      step();
      checkOutput("drain2", C_DRAIN, 2'd0, 16'd0, 1'b0);
      step();
      checkOutput("run_idle", C_NORMAL, 2'd1, 16'd0, 1'b0);

      // Load-use stall for one cycle; the bubble clears the load next cycle.
      applyLoadUse(1'b0, 1'b0);
      checkOutput("lu_rs", C_STALL, 2'd1, 16'd0, 1'b0);
      step();
      applyIdle();
      checkOutput("lu_after", C_NORMAL, 2'd1, 16'd1, 1'b0);
      step();
      applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("lu_r0", C_NORMAL, 2'd1, 16'd1, 1'b0);
      step();
      applyStimulus(5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("lu_rt_unused", C_NORMAL, 2'd1, 16'd1, 1'b0);
      step();
      applyStimulus(5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("lu_rt_used", C_STALL, 2'd1, 16'd1, 1'b0);
      step();

      // Branch together with load-use: flush wins, no stall counted.
      applyStimulus(5'd8, 5'd3, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("br_lu", C_FLUSH, 2'd1, 16'd2, 1'b0);
      step();
      applyIdle();
      checkOutput("br_after", C_NORMAL, 2'd1, 16'd2, 1'b0);
      step();

      // Memory wait acked after three freeze cycles.
      applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("mw_req", C_FREEZE, 2'd1, 16'd2, 1'b0);
      step();
      checkOutput("mw_wait1", C_FREEZE, 2'd2, 16'd3, 1'b0);
      step();
      checkOutput("mw_wait2", C_FREEZE, 2'd2, 16'd4, 1'b0);
      step();
      applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("mw_ack", C_NORMAL, 2'd2, 16'd5, 1'b0);
      step();
      applyIdle();
      checkOutput("mw_done", C_NORMAL, 2'd1, 16'd5, 1'b0);
      step();

      // Ack in the request cycle never freezes.
      applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("mw_fast_ack", C_NORMAL, 2'd1, 16'd5, 1'b0);
      step();
      applyIdle();
      checkOutput("mw_fast_after", C_NORMAL, 2'd1, 16'd5, 1'b0);
      step();

      // Wait plus branch: freeze first, then the branch flushes on the ack.
      applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("mw_br_freeze", C_FREEZE, 2'd1, 16'd5, 1'b0);
      step();
      applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("mw_br_ack", C_FLUSH, 2'd2, 16'd6, 1'b0);
      step();
      applyIdle();
      checkOutput("mw_br_after", C_NORMAL, 2'd1, 16'd6, 1'b0);
      step();

      // Wait released with a load-use pending: stall on the ack cycle.
      applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      applyLoadUse(1'b1, 1'b1);
      checkOutput("mw_lu_ack", C_STALL, 2'd2, 16'd7, 1'b0);
      step();
      applyIdle();
      checkOutput("mw_lu_after", C_NORMAL, 2'd1, 16'd8, 1'b0);
      step();

      // Timeout: four unacked wait cycles set err, freeze continues.
      applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("to_req", C_FREEZE, 2'd1, 16'd8, 1'b0);
      step();
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("to_wait%0d", i + 1), C_FREEZE, 2'd2,
                     16'(9 + i), 1'b0);
         step();
      end
      checkOutput("to_err", C_FREEZE, 2'd2, 16'd13, 1'b1);
      step();
      checkOutput("to_still", C_FREEZE, 2'd2, 16'd14, 1'b1);
      applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("to_ack", C_NORMAL, 2'd2, 16'd14, 1'b1);
      step();
      applyIdle();
      checkOutput("to_run_sticky", C_NORMAL, 2'd1, 16'd14, 1'b1);
      step();

      // Reset clears err and the counters.
      rst = 1'b1;
      #1;
      checkOutput("rst_forced", C_DRAIN, 2'd0, 16'd14, 1'b1);
      step();
      rst = 1'b0;
      #1;
      checkOutput("rst_cleared", C_DRAIN, 2'd0, 16'd0, 1'b0);
      step();
      step();
      checkOutput("rst_run", C_NORMAL, 2'd1, 16'd0, 1'b0);

      // Reset in the middle of a wait restarts the full drain.
      applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      checkOutput("rmw_wait", C_FREEZE, 2'd2, 16'd1, 1'b0);
      step();
      rst = 1'b1;
      #1;
      checkOutput("rmw_rst", C_DRAIN, 2'd0, 16'd2, 1'b0);
      step();
      rst = 1'b0;
      applyIdle();
      checkOutput("rmw_drain1", C_DRAIN, 2'd0, 16'd0, 1'b0);
      step();
      checkOutput("rmw_drain2", C_DRAIN, 2'd0, 16'd0, 1'b0);
      step();
      checkOutput("rmw_run", C_NORMAL, 2'd1, 16'd0, 1'b0);

      // Saturation: preload the counter just below the top, then stall twice.
      force dut.stall_cnt_q = 16'hFFFE;
      #1;
      release dut.stall_cnt_q;
      applyLoadUse(1'b0, 1'b0);
      checkOutput("sat_pre", C_STALL, 2'd1, 16'hFFFE, 1'b0);
      step();
      applyLoadUse(1'b0, 1'b0);
      checkOutput("sat_top", C_STALL, 2'd1, 16'hFFFF, 1'b0);
      step();
      applyIdle();
      checkOutput("sat_hold", C_NORMAL, 2'd1, 16'hFFFF, 1'b0);
      step();

      $display("[TB] %0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

   // Global bound so a stuck run still terminates.
   initial begin
      #100000;
      $display("[TB] FAIL timeout: observed no completion, expected finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
